// File: rtl/nes_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module : nes_clk_pkg
// Purpose: Shared constants for the NES single-clock enable generator.
//          Holds the default rate ratios, the lock delays, the CPU reset
//          length and a helper that sizes fractional accumulators.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package nes_clk_pkg;

   // HDMI pixel rate relative to the 125 MHz master clock: 27/125 -> 27 MHz
   localparam int unsigned HDMI_NUM_DEF         = 27;
   localparam int unsigned HDMI_DEN_DEF         = 125;

   // PPU rate relative to the HDMI pixel rate: 341/1716 -> ~5.365 MHz
   localparam int unsigned PPU_NUM_DEF          = 341;
   localparam int unsigned PPU_DEN_DEF          = 1716;

   // Emulated PLL lock delays, in master cycles
   localparam int unsigned HDMI_LOCK_CYCLES_DEF = 25;
   localparam int unsigned PPU_LOCK_CYCLES_DEF  = 63;

   // Number of ppu_ce pulses the CPU reset outlasts the PPU reset
   localparam int unsigned CPU_RST_LEN_DEF      = 8;

   // Accumulator width for a divider with denominator den. Values stay
   // below den, so clog2(den) bits suffice; never return zero width.
   function automatic int unsigned acc_width(input int unsigned den);
      return (den < 2) ? 1 : $clog2(den);
   endfunction

endpackage : nes_clk_pkg
`default_nettype wire

// File: rtl/frac_ce_div.sv
`default_nettype none
// ============================================================================
// Module : frac_ce_div
// Purpose: Fractional clock-enable divider. Emits NUM single-cycle pulses
//          for every DEN cycles in which en is high (Bresenham style).
// Ports  : clk - clock
//          rst - synchronous active-high reset; clears the accumulator and
//                forces ce low while asserted
//          en  - advance enable; the accumulator only moves when en=1
//          ce  - output enable pulse, only ever high when en=1
// Rev    : 1.0 - initial release
// ============================================================================
module frac_ce_div
   import nes_clk_pkg::*;
#(
   parameter int unsigned NUM = HDMI_NUM_DEF,
   parameter int unsigned DEN = HDMI_DEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic ce
);

   localparam int unsigned W = acc_width(DEN);

   // One extra bit so acc + NUM cannot wrap before DEN is subtracted
   localparam logic [W:0]   NUM_EXT = (W+1)'(NUM);
   localparam logic [W:0]   DEN_EXT = (W+1)'(DEN);
   localparam logic [W-1:0] THRESH  = W'(DEN - NUM);

   generate
      if (NUM >= DEN) begin : g_bad_ratio
         $error("frac_ce_div: NUM (%0d) must be less than DEN (%0d)", NUM, DEN);
      end
   endgenerate

   logic [W-1:0] acc;
   logic [W:0]   acc_next;

   // A pulse fires when adding NUM would reach DEN, i.e. the running
   // fraction crosses an integer boundary.
   assign ce = en & ~rst & (acc >= THRESH);

   always_comb begin
      acc_next = {1'b0, acc} + NUM_EXT - (ce ? DEN_EXT : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= W'(acc_next);
      end
   end

endmodule : frac_ce_div
`default_nettype wire

// File: rtl/nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module : nes_clock_enable_gen
// Purpose: Single-clock replacement for the NES core clock tree. Derives the
//          HDMI, PPU and CPU clock enables from the 125 MHz master clock and
//          sequences emulated lock indications and domain resets.
// Ports  : CLK_125MHZ  - master clock (only clock)
//          rst_clocks  - synchronous active-high reset
//          hdmi_ce     - HDMI pixel enable (27/125 of master)
//          ppu_ce      - PPU enable (341/1716 of hdmi_ce)
//          cpu_ce      - CPU enable (every third ppu_ce)
//          cpu_phase   - CPU sub-phase 0..2, advanced by ppu_ce
//          locked_hdmi - HDMI lock indication (sticky)
//          locked      - full lock indication (sticky)
//          rst_tdms    - TMDS reset  (~locked_hdmi)
//          rst_hdmi    - HDMI reset  (~locked_hdmi)
//          rst_ppu     - PPU reset   (~locked)
//          rst_cpu     - CPU reset, released CPU_RST_LEN ppu_ce after rst_ppu
// Rev    : 1.0 - initial release
// ============================================================================
module nes_clock_enable_gen
   import nes_clk_pkg::*;
#(
   parameter int unsigned HDMI_NUM         = HDMI_NUM_DEF,
   parameter int unsigned HDMI_DEN         = HDMI_DEN_DEF,
   parameter int unsigned PPU_NUM          = PPU_NUM_DEF,
   parameter int unsigned PPU_DEN          = PPU_DEN_DEF,
   parameter int unsigned HDMI_LOCK_CYCLES = HDMI_LOCK_CYCLES_DEF,
   parameter int unsigned PPU_LOCK_CYCLES  = PPU_LOCK_CYCLES_DEF,
   parameter int unsigned CPU_RST_LEN      = CPU_RST_LEN_DEF
) (
   input  logic       CLK_125MHZ,
   input  logic       rst_clocks,
   output logic       hdmi_ce,
   output logic       ppu_ce,
   output logic       cpu_ce,
   output logic [1:0] cpu_phase,
   output logic       locked_hdmi,
   output logic       locked,
   output logic       rst_tdms,
   output logic       rst_hdmi,
   output logic       rst_ppu,
   output logic       rst_cpu
);

   localparam int unsigned HL_W = $clog2(HDMI_LOCK_CYCLES + 1);
   localparam int unsigned PL_W = $clog2(PPU_LOCK_CYCLES + 1);

   generate
      if (HDMI_LOCK_CYCLES < 1 || PPU_LOCK_CYCLES < 1 || CPU_RST_LEN < 1) begin : g_bad_cfg
         $error("nes_clock_enable_gen: lock cycles and CPU_RST_LEN must be >= 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Fractional dividers
   // ------------------------------------------------------------------
   logic ppu_div_rst;

   // The PPU divider only runs once the HDMI side is locked, so its
   // phase is repeatable relative to locked_hdmi.
   assign ppu_div_rst = rst_clocks | ~locked_hdmi;

   frac_ce_div #(
      .NUM (HDMI_NUM),
      .DEN (HDMI_DEN)
   ) u_hdmi_div (
      .clk (CLK_125MHZ),
      .rst (rst_clocks),
      .en  (1'b1),
      .ce  (hdmi_ce)
   );

   frac_ce_div #(
      .NUM (PPU_NUM),
      .DEN (PPU_DEN)
   ) u_ppu_div (
      .clk (CLK_125MHZ),
      .rst (ppu_div_rst),
      .en  (hdmi_ce),
      .ce  (ppu_ce)
   );

   // ------------------------------------------------------------------
   // Lock sequencing: HDMI lock after HDMI_LOCK_CYCLES, full lock after a
   // further PPU_LOCK_CYCLES. Counters freeze once their lock is set.
   // ------------------------------------------------------------------
   logic [HL_W-1:0] hdmi_lock_cnt;
   logic [PL_W-1:0] ppu_lock_cnt;

   always_ff @(posedge CLK_125MHZ) begin
      if (rst_clocks) begin
         hdmi_lock_cnt <= '0;
         ppu_lock_cnt  <= '0;
         locked_hdmi   <= 1'b0;
         locked        <= 1'b0;
      end else if (!locked_hdmi) begin
         if (hdmi_lock_cnt == HL_W'(HDMI_LOCK_CYCLES - 1)) begin
            locked_hdmi <= 1'b1;
         end else begin
            hdmi_lock_cnt <= hdmi_lock_cnt + 1'b1;
         end
      end else if (!locked) begin
         if (ppu_lock_cnt == PL_W'(PPU_LOCK_CYCLES - 1)) begin
            locked <= 1'b1;
         end else begin
            ppu_lock_cnt <= ppu_lock_cnt + 1'b1;
         end
      end
   end

   assign rst_tdms = ~locked_hdmi;
   assign rst_hdmi = ~locked_hdmi;
   assign rst_ppu  = ~locked;

   // ------------------------------------------------------------------
   // CPU phase and CPU reset stretcher, both in the PPU enable domain.
   // rst_clocks is included so the reset takes effect on the very next
   // edge, before the registered locked has dropped.
   // ------------------------------------------------------------------
   logic [CPU_RST_LEN-1:0] cpu_rst_sr;

   always_ff @(posedge CLK_125MHZ) begin
      if (rst_clocks || rst_ppu) begin
         cpu_phase  <= 2'd0;
         cpu_rst_sr <= '1;
      end else if (ppu_ce) begin
         cpu_phase  <= (cpu_phase == 2'd2) ? 2'd0 : cpu_phase + 2'd1;
         cpu_rst_sr <= cpu_rst_sr << 1;
      end
   end

   assign cpu_ce  = ppu_ce & (cpu_phase == 2'd2) & ~rst_ppu;
   assign rst_cpu = cpu_rst_sr[CPU_RST_LEN-1];

endmodule : nes_clock_enable_gen
`default_nettype wire

// File: tb/tb_nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_nes_clock_enable_gen
// Purpose: Self-checking bench for nes_clock_enable_gen. A closed-form rate
//          model predicts every output per cycle into a scoreboard queue,
//          which is compared against the DUT on the falling edge. Aggregate
//          rate/timing checks run alongside.
// Ports  : none
// Rev    : 1.0 - initial release
// ============================================================================
module tb_nes_clock_enable_gen;

   logic       clk;
   logic       rst_clocks;
   logic       hdmi_ce, ppu_ce, cpu_ce;
   logic [1:0] cpu_phase;
   logic       locked_hdmi, locked;
   logic       rst_tdms, rst_hdmi, rst_ppu, rst_cpu;

   nes_clock_enable_gen dut (
      .CLK_125MHZ  (clk),
      .rst_clocks  (rst_clocks),
      .hdmi_ce     (hdmi_ce),
      .ppu_ce      (ppu_ce),
      .cpu_ce      (cpu_ce),
      .cpu_phase   (cpu_phase),
      .locked_hdmi (locked_hdmi),
      .locked      (locked),
      .rst_tdms    (rst_tdms),
      .rst_hdmi    (rst_hdmi),
      .rst_ppu     (rst_ppu),
      .rst_cpu     (rst_cpu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: closed-form pulse positions
   // ------------------------------------------------------------------
   typedef struct {
      bit rst;
      int k;
      bit hce, pce, cce;
      int phase;
      bit lh, lk, rcpu;
   } exp_t;

   exp_t sb_q[$];

   int m_k  = 0;   // cycles since reset release
   int m_nh = 0;   // hdmi_ce seen while HDMI locked
   int m_mp = 0;   // ppu_ce seen while fully locked

   // True when the n-th (zero-based) step of a num/den rate produces a pulse
   function automatic bit frac_hit(input int n, input int num, input int den);
      return (((n + 1) * num) / den) != ((n * num) / den);
   endfunction

   task automatic drive_cycle(input bit r);
      exp_t e;
      @(posedge clk);
      #1;
      rst_clocks = r;
      e.rst = r; e.k = -1; e.hce = 0; e.pce = 0; e.cce = 0;
      e.phase = 0; e.lh = 0; e.lk = 0; e.rcpu = 1;
      if (r) begin
         m_k = 0; m_nh = 0; m_mp = 0;
      end else begin
         e.k     = m_k;
         e.lh    = (m_k >= 25);
         e.lk    = (m_k >= 25 + 63);
         e.hce   = frac_hit(m_k, 27, 125);
         e.pce   = e.hce && e.lh && frac_hit(m_nh, 341, 1716);
         e.phase = e.lk ? (m_mp % 3) : 0;
         e.cce   = e.pce && e.lk && (m_mp % 3 == 2);
         e.rcpu  = !e.lk || (m_mp < 8);
         if (e.hce && e.lh) m_nh++;
         if (e.pce && e.lk) m_mp++;
         m_k++;
      end
      sb_q.push_back(e);
   endtask

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   int win_cnt, b2b, hl_cnt, p_cnt, pl_cnt, c_cnt, epochs_done;
   bit prev_h, chk_fall;

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.rst) begin
            check("rst_hdmi_ce", hdmi_ce, 0);
            check("rst_ppu_ce",  ppu_ce,  0);
            check("rst_cpu_ce",  cpu_ce,  0);
            win_cnt = 0; b2b = 0; prev_h = 0; hl_cnt = 0; p_cnt = 0;
            pl_cnt = 0; c_cnt = 0; chk_fall = 0;
         end else begin
            check("hdmi_ce",     hdmi_ce,     e.hce);
            check("ppu_ce",      ppu_ce,      e.pce);
            check("cpu_ce",      cpu_ce,      e.cce);
            check("cpu_phase",   cpu_phase,   e.phase);
            check("locked_hdmi", locked_hdmi, e.lh);
            check("locked",      locked,      e.lk);
            check("rst_tdms",    rst_tdms,    !e.lh);
            check("rst_hdmi",    rst_hdmi,    !e.lh);
            check("rst_ppu",     rst_ppu,     !e.lk);
            check("rst_cpu",     rst_cpu,     e.rcpu);

            if (chk_fall) begin
               check("rst_cpu_fall", rst_cpu, 0);
               chk_fall = 0;
            end
            if (hdmi_ce && prev_h) b2b++;
            prev_h = hdmi_ce;
            if (e.k < 125 && hdmi_ce) win_cnt++;
            if (e.k == 124) check("hdmi_per_125", win_cnt, 27);

            if (e.lh && hdmi_ce && hl_cnt < 1716) begin
               hl_cnt++;
               if (ppu_ce) begin
                  p_cnt++;
                  if (p_cnt == 1) check("ppu_first_idx", hl_cnt, 6);
               end
               if (hl_cnt == 1716) begin
                  check("ppu_per_1716", p_cnt, 341);
                  check("hdmi_back2back", b2b, 0);
                  epochs_done++;
               end
            end

            if (e.lk && ppu_ce && pl_cnt < 300) begin
               pl_cnt++;
               if (cpu_ce) c_cnt++;
               if (pl_cnt == 7) check("rst_cpu_hold7", rst_cpu, 1);
               if (pl_cnt == 8) begin
                  check("rst_cpu_hold8", rst_cpu, 1);
                  chk_fall = 1;
               end
               if (pl_cnt == 300) begin
                  check("cpu_per_300", c_cnt, 100);
                  epochs_done++;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus: power-on reset, long run, one-cycle mid-run reset, rerun
   // ------------------------------------------------------------------
   initial begin
      rst_clocks  = 1'b1;
      epochs_done = 0;
      for (int i = 0; i < 3; i++)    drive_cycle(1'b1);
      for (int i = 0; i < 9000; i++) drive_cycle(1'b0);
      drive_cycle(1'b1);
      for (int i = 0; i < 9000; i++) drive_cycle(1'b0);
      @(negedge clk);
      #1;
      check("epochs_done", epochs_done, 4);
      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_nes_clock_enable_gen
`default_nettype wire

// File: doc/nes_clock_enable_gen.md
Name: nes_clock_enable_gen

Overview:
Synthesizable single-clock replacement for the MMCM/BUFGCE clock tree of the NES core. From the 125 MHz master clock it produces one-cycle clock enables for the HDMI pixel domain (27 MHz average), the PPU domain (HDMI×341/1716 ≈ 5.365 MHz) and the CPU domain (PPU/3). It also sequences lock indications and the domain resets. It sits at the top of the design and feeds every clock-enabled domain.

Parameters:
HDMI_NUM, 27, numerator of the hdmi_ce rate relative to the master clock
HDMI_DEN, 125, denominator of the hdmi_ce rate relative to the master clock
PPU_NUM, 341, numerator of the ppu_ce rate relative to hdmi_ce
PPU_DEN, 1716, denominator of the ppu_ce rate relative to hdmi_ce
HDMI_LOCK_CYCLES, 25, master cycles from reset release to locked_hdmi
PPU_LOCK_CYCLES, 63, master cycles from locked_hdmi to locked
CPU_RST_LEN, 8, number of ppu_ce pulses that rst_cpu is held after rst_ppu falls

Ports:
CLK_125MHZ  in  1  master clock; the only clock
rst_clocks  in  1  reset, synchronous, active-high
hdmi_ce  out  1  HDMI pixel clock enable
ppu_ce  out  1  PPU clock enable
cpu_ce  out  1  CPU clock enable
cpu_phase  out  2  CPU sub-phase, counts 0..2 in the PPU domain
locked_hdmi  out  1  HDMI "PLL" lock indication
locked  out  1  full lock indication (PPU)
rst_tdms  out  1  equals ~locked_hdmi
rst_hdmi  out  1  equals ~locked_hdmi
rst_ppu  out  1  equals ~locked
rst_cpu  out  1  CPU reset

Behaviour:
- Everything is clocked on the rising edge of CLK_125MHZ.
- rst_clocks=1, whether at startup or mid-run, forces on the next edge:
  - accumulators, counters and cpu_phase to 0
  - locked_hdmi=0 and locked=0, so rst_tdms=rst_hdmi=rst_ppu=1
  - the CPU reset shift register to all ones, so rst_cpu=1
  - hdmi_ce, ppu_ce and cpu_ce are 0 while reset is asserted.
- HDMI enable (fractional divider):
  - hdmi_acc has width clog2(HDMI_DEN) and runs whenever not in reset.
  - hdmi_ce = (hdmi_acc >= HDMI_DEN-HDMI_NUM), combinational from the register.
  - Each edge: hdmi_acc <= hdmi_acc + HDMI_NUM - (hdmi_ce ? HDMI_DEN : 0).
  - Result: exactly 27 pulses per 125 cycles, all single-cycle, never two back-to-back. The first pulse is on the 5th cycle after reset release (acc sequence 0, 27, 54, 81, 108).
- Lock sequencing:
  - A lock counter counts master cycles after reset release.
  - locked_hdmi goes to 1 once HDMI_LOCK_CYCLES cycles have elapsed.
  - A second counter starts when locked_hdmi=1; locked goes to 1 after PPU_LOCK_CYCLES further cycles.
  - Both lock signals are sticky until rst_clocks.
- PPU enable:
  - ppu_acc has width clog2(PPU_DEN) and is held at 0 while locked_hdmi=0.
  - ppu_ce = hdmi_ce & locked_hdmi & (ppu_acc >= PPU_DEN-PPU_NUM).
  - ppu_acc updates only when hdmi_ce=1, using the same rule as hdmi_acc.
  - Result: 341 ppu_ce per 1716 hdmi_ce. The first pulse is on the 6th hdmi_ce after locked_hdmi.
- CPU:
  - cpu_phase is held at 0 while rst_ppu=1.
  - Otherwise, on each ppu_ce, cpu_phase advances 0→1→2→0.
  - cpu_ce = ppu_ce & (cpu_phase==2) & ~rst_ppu, i.e. every third ppu_ce.
- rst_cpu:
  - The shift register is CPU_RST_LEN bits wide.
  - It is loaded with all ones on any cycle where rst_ppu=1.
  - Otherwise it shifts left, filling with 0, on each ppu_ce.
  - rst_cpu is the MSB, so it falls on the CPU_RST_LEN-th ppu_ce after rst_ppu falls.
- Arithmetic: unsigned only; widths sized so acc+NUM never overflows. NUM<DEN is required and is checked by an elaboration assertion.

Decomposition:
- Package nes_clk_pkg holds the default ratio constants (27/125, 341/1716), lock cycle counts and CPU_RST_LEN.
- One sub-module, frac_ce_div (parameters NUM, DEN; ports clk, rst, en, ce), is instantiated twice:
  - HDMI instance: en=1.
  - PPU instance: en=hdmi_ce, rst=rst_clocks|~locked_hdmi.

Test Plan:
- Reset release at cycle 0 → hdmi_ce first at cycle 4; 27 pulses in any 125-cycle window; no consecutive pulses.
- Count cycles → locked_hdmi=1 and rst_hdmi/rst_tdms=0 at cycle 25; locked=1 and rst_ppu=0 at cycle 88.
- Run 1716 hdmi_ce after lock → exactly 341 ppu_ce, each coincident with an hdmi_ce; first on the 6th hdmi_ce.
- After locked → cpu_phase sequence 0,1,2 per ppu_ce; cpu_ce only on phase-2 ppu_ce; 100 cpu_ce per 300 ppu_ce.
- After rst_ppu falls → rst_cpu stays 1 through 7 ppu_ce and falls at the 8th.
- Assert rst_clocks mid-run for 1 cycle → next cycle all ce=0, locks=0, rst_cpu=1, cpu_phase=0; the full sequence repeats with identical timing.
